// File: rtl/gf_mul_sched.sv
// rtl/gf_mul_sched.sv - shared iterative GF(2^8) multiplier with two-requester round-robin scheduler
module gf_mul_sched #(
    parameter logic [7:0] POLY = 8'h1B,
    parameter int         ITER = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_data
);
    localparam int CW = $clog2(ITER + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state;
    logic [7:0]    acc;
    logic [7:0]    a_r;
    logic [7:0]    b_r;
    logic [CW-1:0] cnt;
    logic          id_r;
    logic          last;
    logic          grant0;
    logic          grant1;

    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? POLY : 8'h00);
    endfunction

    // On a tie the requester that did not win last time is served.
    always_comb begin
        grant0     = req0_valid & (~req1_valid | last);
        grant1     = req1_valid & (~req0_valid | ~last);
        req0_ready = rst & (state == IDLE) & grant0;
        req1_ready = rst & (state == IDLE) & grant1;
    end

    assign rsp_data = acc;
    assign rsp_id   = id_r;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            acc       <= 8'h00;
            a_r       <= 8'h00;
            b_r       <= 8'h00;
            cnt       <= '0;
            id_r      <= 1'b0;
            last      <= 1'b1;
            rsp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0_ready) begin
                        a_r   <= req0_a;
                        b_r   <= req0_b;
                        acc   <= 8'h00;
                        cnt   <= '0;
                        id_r  <= 1'b0;
                        last  <= 1'b0;
                        state <= BUSY;
                    end else if (req1_ready) begin
                        a_r   <= req1_a;
                        b_r   <= req1_b;
                        acc   <= 8'h00;
                        cnt   <= '0;
                        id_r  <= 1'b1;
                        last  <= 1'b1;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    acc <= acc ^ (b_r[0] ? a_r : 8'h00);
                    a_r <= xtime(a_r);
                    b_r <= b_r >> 1;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(ITER - 1)) begin
                        state     <= DONE;
                        rsp_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gf_mul_sched.sv
// tb/tb_gf_mul_sched.sv - scoreboard bench for gf_mul_sched
module tb_gf_mul_sched;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0_valid = 1'b0;
    logic       req1_valid = 1'b0;
    logic       rsp_ready = 1'b1;
    logic [7:0] req0_a = 8'h00;
    logic [7:0] req0_b = 8'h00;
    logic [7:0] req1_a = 8'h00;
    logic [7:0] req1_b = 8'h00;
    logic       req0_ready;
    logic       req1_ready;
    logic       rsp_valid;
    logic       rsp_id;
    logic [7:0] rsp_data;

    gf_mul_sched dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         rsp_cnt = 0;
    int         acc_cnt = 0;
    int         last_acc = -1;
    int         last_hs_cyc = 0;
    bit         gap_mode = 1'b0;
    bit         interval_mode = 1'b0;
    bit         arb_mode = 1'b0;
    logic [8:0] exp_q[$];
    int         acc_cyc_q[$];
    int         arb_ids[$];
    logic       prev_valid = 1'b0;
    logic       prev_hs = 1'b0;
    logic [8:0] prev_rsp = 9'h000;
    logic [8:0] last_rsp = 9'h000;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Schoolbook carry-less product followed by long division by x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_ref(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = 15'h0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--)
            if (p[i]) p = p ^ (15'h11B << (i - 8));
        return p[7:0];
    endfunction

    always @(negedge clk) begin
        cyc++;
        chk("one_ready", int'(req0_ready & req1_ready), 0);
        if (!rst) begin
            chk("rst_ready", int'(req0_ready | req1_ready), 0);
            exp_q.delete();
            acc_cyc_q.delete();
            prev_valid = 1'b0;
            prev_hs = 1'b0;
        end else begin
            if (req0_valid && req0_ready) begin
                exp_q.push_back({1'b0, gf_ref(req0_a, req0_b)});
                acc_cyc_q.push_back(cyc);
            end
            if (req1_valid && req1_ready) begin
                exp_q.push_back({1'b1, gf_ref(req1_a, req1_b)});
                acc_cyc_q.push_back(cyc);
            end
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                acc_cnt++;
                if (gap_mode) begin
                    chk("reissue_gap", cyc - last_hs_cyc, 1);
                    gap_mode = 1'b0;
                end
                if (interval_mode && last_acc >= 0) chk("issue_gap", cyc - last_acc, 10);
                last_acc = cyc;
            end
            if (rsp_valid) chk("ready_in_done", int'(req0_ready | req1_ready), 0);
            if (rsp_valid && !prev_valid) begin
                if (acc_cyc_q.size() > 0) chk("latency", cyc - acc_cyc_q[0], 9);
                else chk("spurious_rsp", acc_cyc_q.size(), 1);
            end
            if (rsp_valid && prev_valid && !prev_hs) chk("hold", int'({rsp_id, rsp_data}), int'(prev_rsp));
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", exp_q.size(), 1);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    void'(acc_cyc_q.pop_front());
                    chk("rsp_id", int'(rsp_id), int'(e[8]));
                    chk("rsp_data", int'(rsp_data), int'(e[7:0]));
                end
                if (arb_mode) arb_ids.push_back(int'(rsp_id));
                last_rsp = {rsp_id, rsp_data};
                last_hs_cyc = cyc;
                rsp_cnt++;
            end
            prev_valid = rsp_valid;
            prev_hs = rsp_valid & rsp_ready;
            prev_rsp = {rsp_id, rsp_data};
        end
    end

    task automatic issue(input bit id, input logic [7:0] a, input logic [7:0] b);
        int n;
        int seen;
        n = 0;
        seen = acc_cnt;
        @(posedge clk);
        #2;
        if (id == 1'b0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b;
        end
        while (acc_cnt == seen && n < 200) begin
            @(posedge clk);
            n++;
        end
        #2;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (n >= 200) chk("accept_timeout", n, 0);
    endtask

    task automatic wait_rsp(input int target);
        int n;
        n = 0;
        while (rsp_cnt < target && n < 300) begin
            @(posedge clk);
            n++;
        end
        #2;
        if (rsp_cnt < target) chk("rsp_timeout", rsp_cnt, target);
    endtask

    task automatic run_one(input bit id, input logic [7:0] a, input logic [7:0] b);
        int t;
        t = rsp_cnt + 1;
        issue(id, a, b);
        wait_rsp(t);
    endtask

    logic [7:0] p2_a[5] = '{8'h57, 8'h02, 8'h03, 8'h0E, 8'h01};
    logic [7:0] p2_b[5] = '{8'h13, 8'h87, 8'h6E, 8'h00, 8'hA5};
    logic [7:0] p2_e[5] = '{8'hFE, 8'h15, 8'hB2, 8'h00, 8'hA5};

    initial begin
        int saved;
        int n;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("rst_ready0", int'(req0_ready), 0);
            chk("rst_ready1", int'(req1_ready), 0);
            chk("rst_valid", int'(rsp_valid), 0);
        end
        chk("rst_data", int'(rsp_data), 0);
        chk("rst_id", int'(rsp_id), 0);

        @(posedge clk);
        #2;
        rst = 1'b1;
        req1_valid = 1'b0;
        req0_a = 8'h57;
        req0_b = 8'h83;
        @(negedge clk);
        #1;
        chk("p1_first_ready", int'(req0_ready), 1);
        @(posedge clk);
        #2;
        req0_valid = 1'b0;
        wait_rsp(1);
        chk("p1_rsp", int'(last_rsp), int'({1'b0, 8'hC1}));

        for (int i = 0; i < 5; i++) begin
            run_one(1'b0, p2_a[i], p2_b[i]);
            chk("p2_prod", int'(last_rsp[7:0]), int'(p2_e[i]));
        end

        rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        arb_mode = 1'b1;
        interval_mode = 1'b1;
        last_acc = -1;
        saved = rsp_cnt;
        req0_a = 8'h02; req0_b = 8'h87;
        req1_a = 8'h57; req1_b = 8'h83;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        wait_rsp(saved + 4);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        arb_mode = 1'b0;
        interval_mode = 1'b0;
        chk("p3_count", arb_ids.size(), 4);
        for (int i = 0; i < 4 && i < arb_ids.size(); i++) chk("p3_id_seq", arb_ids[i], i % 2);
        repeat (3) @(posedge clk);
        #2;

        rsp_ready = 1'b0;
        issue(1'b0, 8'h57, 8'h13);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(posedge clk);
            n++;
        end
        #2;
        chk("p4_valid_rise", int'(rsp_valid), 1);
        req1_a = 8'h09; req1_b = 8'h0B;
        req1_valid = 1'b1;
        repeat (20) @(posedge clk);
        #2;
        chk("p4_valid_held", int'(rsp_valid), 1);
        chk("p4_data_held", int'(rsp_data), 8'hFE);
        chk("p4_no_ready", int'(req1_ready), 0);
        saved = rsp_cnt;
        gap_mode = 1'b1;
        rsp_ready = 1'b1;
        wait_rsp(saved + 2);
        req1_valid = 1'b0;
        chk("p4_gap_seen", int'(gap_mode), 0);
        chk("p4_second", int'(last_rsp), int'({1'b1, 8'h53}));
        repeat (3) @(posedge clk);
        #2;

        issue(1'b0, 8'h57, 8'h83);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        saved = rsp_cnt;
        repeat (15) @(posedge clk);
        #2;
        chk("p5_no_rsp", rsp_cnt, saved);
        run_one(1'b1, 8'h09, 8'h0B);
        chk("p5_rsp", int'(last_rsp), int'({1'b1, 8'h53}));

        saved = rsp_cnt + 1;
        issue(1'b0, 8'hC3, 8'hA7);
        n = 0;
        while (rsp_cnt < saved && n < 50) begin
            req0_a = 8'($urandom);
            req0_b = 8'($urandom);
            @(posedge clk);
            #2;
            n++;
        end
        chk("p6_done", rsp_cnt, saved);
        chk("p6_rsp", int'(last_rsp), int'({1'b0, gf_ref(8'hC3, 8'hA7)}));

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
